// File: rtl/tone_seq_pkg.sv
// Shared types and defaults for the tone sequence checker.
// The optional inter-tone timeout is enabled with TONE_SEQ_TIMEOUT_EN.
package tone_seq_pkg;

    localparam int DEF_PASS_LEN = 5;
    localparam int DEF_TONE_W   = 16;
    localparam int DEF_NO_TONE  = 16;

    typedef logic [DEF_TONE_W-1:0] tone_t;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } tone_seq_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tone_seq_dedup.sv
// Tone de-duplication: tracks the previous tone and raises an accept strobe
// for a tone that is neither NO_TONE nor a repeat of the previous code.
module tone_seq_dedup
    import tone_seq_pkg::*;
#(
    parameter int TONE_W  = DEF_TONE_W,
    parameter int NO_TONE = DEF_NO_TONE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [TONE_W-1:0] i_code,
    output logic              o_accept
);

    localparam logic [TONE_W-1:0] NO_TONE_C = TONE_W'(NO_TONE);

    logic [TONE_W-1:0] r_prev;
    logic              w_take;

    assign w_take   = i_enable && i_valid;
    assign o_accept = w_take && (i_code != NO_TONE_C) && (i_code != r_prev);

    // NO_TONE resets prev, a repeat leaves it unchanged: both equal "prev <= code".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= NO_TONE_C;
        end else if (i_flush) begin
            r_prev <= NO_TONE_C;
        end else if (w_take) begin
            r_prev <= i_code;
        end
    end

endmodule

// File: rtl/tone_sequence_checker.sv
// Password engine: collects de-duplicated tones, compares against pass_code,
// counts failures with a timed lockout. Optional idle timeout: TONE_SEQ_TIMEOUT_EN.
module tone_sequence_checker
    import tone_seq_pkg::*;
#(
    parameter int PASS_LEN       = DEF_PASS_LEN,
    parameter int TONE_W         = DEF_TONE_W,
    parameter int NO_TONE        = DEF_NO_TONE,
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 1000000,
    parameter int TIMEOUT_CYCLES = 500000,
    localparam int PROG_W        = $clog2(PASS_LEN + 1),
    localparam int FC_W          = $clog2(MAX_FAIL + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       tone_valid,
    input  logic [TONE_W-1:0]          tone_code,
    input  logic [PASS_LEN*TONE_W-1:0] pass_code,
    input  logic                       clear,
    output logic                       unlocked,
    output logic                       fail,
    output logic                       locked,
    output logic                       timeout,
    output logic [PROG_W-1:0]          progress,
    output logic [FC_W-1:0]            fail_count
);

    localparam int LOCK_W = cnt_w(LOCK_CYCLES);

    localparam logic [PROG_W-1:0] PASS_LAST = PROG_W'(PASS_LEN - 1);
    localparam logic [FC_W-1:0]   FAIL_LAST = FC_W'(MAX_FAIL - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    tone_seq_state_t     r_state, w_state_next;
    logic [PROG_W-1:0]   r_progress, w_progress_next;
    logic [FC_W-1:0]     r_fail_count, w_fail_count_next;
    logic                r_fail, w_fail_next;
    logic [LOCK_W-1:0]   r_lock_cnt, w_lock_cnt_next;
    logic [TONE_W-1:0]   r_buf [PASS_LEN];
    logic [PASS_LEN-1:0] w_entry_match;
    logic                w_match;
    logic                w_accept;
    logic                w_expire;
    logic                w_dedup_en;
    logic                w_dedup_flush;

    // Clear and timeout expiry both beat a simultaneous tone.
    assign w_dedup_en    = (r_state == ST_ENTRY) && !clear && !w_expire;
    assign w_dedup_flush = (r_state != ST_ENTRY) || clear || w_expire;

    tone_seq_dedup #(
        .TONE_W  (TONE_W),
        .NO_TONE (NO_TONE)
    ) u_dedup (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (w_dedup_en),
        .i_flush  (w_dedup_flush),
        .i_valid  (tone_valid),
        .i_code   (tone_code),
        .o_accept (w_accept)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_progress] <= tone_code;
        end
    end

    for (genvar gi = 0; gi < PASS_LEN; gi++) begin : g_cmp
        assign w_entry_match[gi] = (r_buf[gi] == pass_code[gi*TONE_W +: TONE_W]);
    end
    assign w_match = &w_entry_match;

`ifdef TONE_SEQ_TIMEOUT_EN
    localparam int                IDLE_W    = cnt_w(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_timeout;

    assign w_expire = (r_state == ST_ENTRY) && (r_progress != '0) && !clear &&
                      (r_idle_cnt == IDLE_LAST);

    // Restarted only by an accepted tone; dropped tones keep it running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_accept || w_expire || clear || (r_state != ST_ENTRY) || (r_progress == '0)) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_expire         = 1'b0;
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ENTRY;
            r_progress   <= '0;
            r_fail_count <= '0;
            r_fail       <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_progress   <= w_progress_next;
            r_fail_count <= w_fail_count_next;
            r_fail       <= w_fail_next;
            r_lock_cnt   <= w_lock_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_progress_next   = r_progress;
        w_fail_count_next = r_fail_count;
        w_fail_next       = 1'b0;
        w_lock_cnt_next   = r_lock_cnt;
        case (r_state)
            ST_ENTRY: begin
                if (clear || w_expire) begin
                    w_progress_next = '0;
                end else if (w_accept) begin
                    w_progress_next = r_progress + 1'b1;
                    if (r_progress == PASS_LAST) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_progress_next = '0;
                if (w_match) begin
                    w_state_next      = ST_UNLOCKED;
                    w_fail_count_next = '0;
                end else begin
                    w_fail_next       = 1'b1;
                    w_fail_count_next = r_fail_count + 1'b1;
                    if (r_fail_count == FAIL_LAST) begin
                        w_state_next    = ST_LOCKOUT;
                        w_lock_cnt_next = '0;
                    end else begin
                        w_state_next = ST_ENTRY;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (clear) begin
                    w_state_next = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                // Entered on the failing edge, so LOCK_CYCLES edges here give LOCK_CYCLES high cycles.
                if (r_lock_cnt == LOCK_LAST) begin
                    w_state_next      = ST_ENTRY;
                    w_fail_count_next = '0;
                    w_lock_cnt_next   = '0;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ENTRY;
            end
        endcase
    end

    assign unlocked   = (r_state == ST_UNLOCKED);
    assign locked     = (r_state == ST_LOCKOUT);
    assign fail       = r_fail;
    assign progress   = r_progress;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_tone_sequence_checker.sv
// Bench for tone_sequence_checker: directed scenarios plus random tones, checked
// every cycle against a queue-based model. Timeout scenario runs with TONE_SEQ_TIMEOUT_EN.
module tb_tone_sequence_checker;
    import tone_seq_pkg::*;

    localparam int PASS_LEN       = 5;
    localparam int TONE_W         = 16;
    localparam int NO_TONE        = 16;
    localparam int MAX_FAIL       = 3;
    localparam int LOCK_CYCLES    = 50;
    localparam int TIMEOUT_CYCLES = 20;
`ifdef TONE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                       clk;
    logic                       reset_n;
    logic                       tone_valid;
    tone_t                      tone_code;
    logic [PASS_LEN*TONE_W-1:0] pass_code;
    logic                       clear;
    logic                       unlocked, fail, locked, timeout;
    logic [2:0]                 progress;
    logic [1:0]                 fail_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;
    int pass_arr [PASS_LEN] = '{5, 4, 3, 2, 1};

    // Model state: accepted tones in a queue, lockout as cycles remaining.
    int m_tones[$];
    int m_prev, m_fc, m_lock_left, m_idle;
    bit m_unlocked, m_check, m_fail, m_timeout;

    tone_sequence_checker #(
        .PASS_LEN       (PASS_LEN),
        .TONE_W         (TONE_W),
        .NO_TONE        (NO_TONE),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tone_valid (tone_valid),
        .tone_code  (tone_code),
        .pass_code  (pass_code),
        .clear      (clear),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked     (locked),
        .timeout    (timeout),
        .progress   (progress),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tones.delete();
        m_prev      = NO_TONE;
        m_fc        = 0;
        m_lock_left = 0;
        m_idle      = 0;
        m_unlocked  = 0;
        m_check     = 0;
        m_fail      = 0;
        m_timeout   = 0;
    endtask

    task automatic model_step(input bit v, input int code, input bit clr);
        bit ok;
        m_fail    = 0;
        m_timeout = 0;
        if (m_check) begin
            m_check = 0;
            ok = 1;
            foreach (m_tones[i]) if (m_tones[i] != pass_arr[i]) ok = 0;
            if (ok) begin
                m_unlocked = 1;
                m_fc       = 0;
            end else begin
                m_fail = 1;
                m_fc++;
                if (m_fc == MAX_FAIL) m_lock_left = LOCK_CYCLES;
            end
            m_tones.delete();
            m_prev = NO_TONE;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fc = 0;
        end else if (m_unlocked) begin
            if (clr) m_unlocked = 0;
        end else if (clr) begin
            m_tones.delete();
            m_prev = NO_TONE;
            m_idle = 0;
        end else if (TO_EN && m_tones.size() > 0 && m_idle + 1 == TIMEOUT_CYCLES) begin
            m_timeout = 1;
            m_tones.delete();
            m_prev = NO_TONE;
            m_idle = 0;
        end else begin
            ok = 0;
            if (v) begin
                if (code == NO_TONE) m_prev = NO_TONE;
                else if (code != m_prev) begin
                    m_tones.push_back(code);
                    m_prev = code;
                    ok = 1;
                end
            end
            if (ok) begin
                m_idle = 0;
                if (m_tones.size() == PASS_LEN) m_check = 1;
            end else if (m_tones.size() > 0) begin
                m_idle++;
            end
        end
    endtask

    // One clock: inputs held across the edge, model advanced, returns at edge+1.
    task automatic step(input bit v, input int code, input bit clr);
        tone_valid = v;
        tone_code  = tone_t'(code);
        clear      = clr;
        @(posedge clk);
        model_step(v, code, clr);
        #1;
        tone_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic send_seq(input int seq[$]);
        foreach (seq[i]) step(1'b1, seq[i], 1'b0);
    endtask

    task automatic wrong_entry();
        int q[$];
        q = '{5, 4, 3, 1, 2};
        send_seq(q);
        step(1'b0, 0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        model_step(1'b0, 0, 1'b0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_unlocked"}, unlocked, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_progress"}, progress, 0);
        check({tag, "_fail_count"}, fail_count, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_unlocked", unlocked, m_unlocked);
            check("cyc_fail", fail, m_fail);
            check("cyc_locked", locked, (m_lock_left > 0) ? 1 : 0);
            check("cyc_timeout", timeout, m_timeout);
            check("cyc_progress", progress, m_tones.size());
            check("cyc_fail_count", fail_count, m_fc);
        end
    end

    initial begin
        int q[$];
        int lock_len;
        reset_n    = 1'b0;
        tone_valid = 1'b0;
        clear      = 1'b0;
        tone_code  = '0;
        for (int i = 0; i < PASS_LEN; i++) pass_code[i*TONE_W +: TONE_W] = TONE_W'(pass_arr[i]);
        model_reset();
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_unlocked", unlocked, 0);
        check("reset_locked", locked, 0);
        check("reset_timeout", timeout, 0);
        check("reset_progress", progress, 0);
        check("reset_fail_count", fail_count, 0);
        #2;
        reset_n = 1'b1;

        // Correct entry with duplicates and NO_TONE gaps.
        q = '{5,5,5,16,16,4,4,16,16,16,3,3,3,3,16,2,16,16,16,1};
        send_seq(q);
        check("ok_progress_full", progress, 5);
        step(1'b0, 0, 1'b0);
        check("ok_unlocked", unlocked, 1);
        check("ok_model_unlocked", m_unlocked, 1);
        check("ok_progress_zero", progress, 0);
        check("ok_fail_count", fail_count, 0);
        step(1'b1, 5, 1'b0);
        check("unl_tone_ignored", progress, 0);
        step(1'b0, 0, 1'b1);
        check("relock", unlocked, 0);

        // Single wrong entry.
        wrong_entry();
        check("bad_fail", fail, 1);
        check("bad_fail_count", fail_count, 1);
        check("bad_model_fc", m_fc, 1);
        check("bad_progress", progress, 0);
        check("bad_locked", locked, 0);
        step(1'b0, 0, 1'b0);
        check("bad_fail_pulse_end", fail, 0);

        // Reach lockout and measure it while tones and clear keep arriving.
        wrong_entry();
        wrong_entry();
        check("lock_rise", locked, 1);
        check("lock_fail_pulse", fail, 1);
        check("lock_fail_count", fail_count, 3);
        lock_len = 1;
        while (locked && lock_len < 200) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 1'($urandom_range(0, 3) == 0));
            if (locked) lock_len++;
        end
        check("lock_len", lock_len, LOCK_CYCLES);
        check("lock_fc_cleared", fail_count, 0);
        check("lock_progress", progress, 0);
        q = '{5, 4, 3, 2, 1};
        send_seq(q);
        step(1'b0, 0, 1'b0);
        check("post_lock_unlocked", unlocked, 1);
        step(1'b0, 0, 1'b1);

        // De-duplication corner cases.
        step(1'b1, 5, 1'b0);
        step(1'b1, 5, 1'b0);
        check("dup_5_5", progress, 1);
        step(1'b0, 0, 1'b1);
        check("clear_progress", progress, 0);
        q = '{5, 16, 5};
        send_seq(q);
        check("dup_5_16_5", progress, 2);
        check("dup_model", m_tones.size(), 2);
        step(1'b0, 0, 1'b1);

        // Reset mid-entry.
        q = '{1, 2, 3};
        send_seq(q);
        check("mid_progress", progress, 3);
        async_reset("rst_mid");
        step(1'b1, 2, 1'b0);
        check("rst_mid_restart", progress, 1);
        step(1'b0, 0, 1'b1);

        // Reset during lockout.
        wrong_entry();
        wrong_entry();
        wrong_entry();
        check("lock2_rise", locked, 1);
        async_reset("rst_lock");
        step(1'b1, 5, 1'b0);
        check("rst_lock_restart", progress, 1);
        step(1'b0, 0, 1'b1);

`ifdef TONE_SEQ_TIMEOUT_EN
        wrong_entry();
        q = '{5, 4};
        send_seq(q);
        repeat (TIMEOUT_CYCLES - 1) step(1'b1, 4, 1'b0);
        check("to_not_yet", timeout, 0);
        check("to_progress_held", progress, 2);
        step(1'b1, 3, 1'b0);
        check("to_pulse", timeout, 1);
        check("to_model_pulse", m_timeout, 1);
        check("to_progress", progress, 0);
        check("to_fail_count", fail_count, 1);
        step(1'b0, 0, 1'b0);
        check("to_pulse_end", timeout, 0);
        step(1'b0, 0, 1'b1);
`endif

        // Random traffic with occasional correct entries.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 4) begin
                for (int i = 0; i < PASS_LEN; i++) step(1'b1, pass_arr[i], 1'b0);
            end else begin
                int sel;
                sel = int'($urandom_range(0, 5));
                step(1'($urandom_range(0, 2) != 0), (sel == 5) ? NO_TONE : sel + 1,
                     1'($urandom_range(0, 49) == 0));
            end
        end

        @(negedge clk);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
